// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the round-robin SRAM arbiter.
package sram_arb_pkg;

  localparam int CntW      = 32;
  localparam int MaxNumReq = 8;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int IdxW = idx_width(MaxNumReq);

  typedef logic [IdxW-1:0] req_idx_t;

endpackage

// File: rtl/sram_arb_id_fifo.sv
// Synchronous FIFO of requester indices, one entry per outstanding SRAM access.
// A push at full is accepted only when a pop frees the head in the same cycle.
module sram_arb_id_fifo
  import sram_arb_pkg::*;
#(
  parameter int Depth = 2,
  parameter int Width = IdxW
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [Width-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(Depth+1)-1:0] count_o,
  output logic [Width-1:0]           head_o
);

  localparam int PtrW  = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntFW = $clog2(Depth + 1);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  rptr_q, wptr_q;
  logic [CntFW-1:0] cnt_q;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CntFW'(Depth));
  assign count_o = cnt_q;
  assign head_o  = mem[rptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= ptr_inc(wptr_q);
      if (do_pop)  rptr_q <= ptr_inc(rptr_q);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/sram_rr_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between NumReq requesters.
// Optional grant/stall statistics are enabled with SRAM_RR_ARBITER_STATS_EN.
module sram_rr_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NumReq      = 2,
  parameter int SramAw      = 11,
  parameter int SramDw      = 32,
  parameter int Outstanding = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NumReq-1:0]        req_i,
  input  logic [NumReq-1:0]        we_i,
  input  logic [NumReq*SramAw-1:0] addr_i,
  input  logic [NumReq*SramDw-1:0] wdata_i,
  input  logic [NumReq*SramDw-1:0] wmask_i,
  output logic [NumReq-1:0]        gnt_o,
  output logic [NumReq-1:0]        rvalid_o,
  output logic [SramDw-1:0]        rdata_o,
  output logic                     sram_req_o,
  output logic                     sram_we_o,
  output logic [SramAw-1:0]        sram_addr_o,
  output logic [SramDw-1:0]        sram_wdata_o,
  output logic [SramDw-1:0]        sram_wmask_o,
  input  logic                     sram_rvalid_i,
  input  logic [SramDw-1:0]        sram_rdata_i,
  output logic                     err_o,
  output logic [NumReq*CntW-1:0]   grant_cnt_o,
  output logic [CntW-1:0]          stall_cnt_o
);

  localparam int FcW = $clog2(Outstanding + 1);

  req_idx_t         ptr_q, winner, sel, head;
  logic [NumReq-1:0] req_rot;
  int               win_sum;
  logic             found, can_accept, grant, rsp_ok;
  logic             fifo_full, fifo_empty;
  logic [FcW-1:0]   fifo_cnt;

  // A response pops the head this cycle, so a full FIFO can still take a push.
  assign can_accept = (fifo_cnt < FcW'(Outstanding)) | (fifo_full & sram_rvalid_i);

  assign req_rot = NumReq'({req_i, req_i} >> ptr_q);

  // Downward scan: the last hit is the requester closest to ptr.
  always_comb begin
    found   = 1'b0;
    win_sum = 0;
    for (int off = NumReq - 1; off >= 0; off--) begin
      if (req_rot[off]) begin
        found   = 1'b1;
        win_sum = int'(ptr_q) + off;
      end
    end
    winner = (win_sum >= NumReq) ? req_idx_t'(win_sum - NumReq) : req_idx_t'(win_sum);
  end

  assign grant  = ~rst_i & found & can_accept;
  assign rsp_ok = ~rst_i & sram_rvalid_i & ~fifo_empty;
  assign sel    = grant ? winner : ptr_q;

  always_comb begin
    gnt_o        = '0;
    rvalid_o     = '0;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    sram_wmask_o = '0;
    for (int i = 0; i < NumReq; i++) begin
      gnt_o[i]    = grant && (winner == req_idx_t'(i));
      rvalid_o[i] = rsp_ok && (head == req_idx_t'(i));
      if (sel == req_idx_t'(i)) begin
        sram_we_o    = we_i[i];
        sram_addr_o  = addr_i[i*SramAw +: SramAw];
        sram_wdata_o = wdata_i[i*SramDw +: SramDw];
        sram_wmask_o = wmask_i[i*SramDw +: SramDw];
      end
    end
  end

  assign sram_req_o = grant;
  assign rdata_o    = sram_rdata_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
      err_o <= 1'b0;
    end else begin
      if (grant) ptr_q <= (winner == req_idx_t'(NumReq - 1)) ? '0 : winner + 1'b1;
      if (sram_rvalid_i && fifo_empty) err_o <= 1'b1;
    end
  end

  sram_arb_id_fifo #(
    .Depth (Outstanding),
    .Width (IdxW)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (grant),
    .wdata_i (winner),
    .pop_i   (rsp_ok),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt),
    .head_o  (head)
  );

`ifdef SRAM_RR_ARBITER_STATS_EN
  logic [CntW-1:0] grant_cnt_q [NumReq];
  logic [CntW-1:0] stall_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumReq; i++) grant_cnt_q[i] <= '0;
      stall_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NumReq; i++) begin
        if (gnt_o[i] && (grant_cnt_q[i] != '1)) grant_cnt_q[i] <= grant_cnt_q[i] + 1'b1;
      end
      if ((|req_i) && !can_accept && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  for (genvar g = 0; g < NumReq; g++) begin : g_gcnt
    assign grant_cnt_o[g*CntW +: CntW] = grant_cnt_q[g];
  end
  assign stall_cnt_o = stall_cnt_q;
`else
  assign grant_cnt_o = '0;
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Self-checking bench for sram_rr_arbiter: directed scenarios plus random traffic
// against a queue-based reference model and a latency-1 RAM model.
module tb_sram_rr_arbiter;

  localparam int N   = 2;
  localparam int AW  = 11;
  localparam int DW  = 32;
  localparam int OUT = 2;
`ifdef SRAM_RR_ARBITER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic [N-1:0]    req_i = '0, we_i = '0;
  logic [N*AW-1:0] addr_i = '0;
  logic [N*DW-1:0] wdata_i = '0, wmask_i = '0;
  logic [N-1:0]    gnt_o, rvalid_o;
  logic [DW-1:0]   rdata_o;
  logic            sram_req_o, sram_we_o;
  logic [AW-1:0]   sram_addr_o;
  logic [DW-1:0]   sram_wdata_o, sram_wmask_o;
  logic            sram_rvalid_i = 1'b0;
  logic [DW-1:0]   sram_rdata_i = '0;
  logic            err_o;
  logic [N*32-1:0] grant_cnt_o;
  logic [31:0]     stall_cnt_o;

  sram_rr_arbiter #(.NumReq(N), .SramAw(AW), .SramDw(DW), .Outstanding(OUT)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .wmask_i(wmask_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
    .rdata_o(rdata_o), .sram_req_o(sram_req_o), .sram_we_o(sram_we_o),
    .sram_addr_o(sram_addr_o), .sram_wdata_o(sram_wdata_o), .sram_wmask_o(sram_wmask_o),
    .sram_rvalid_i(sram_rvalid_i), .sram_rdata_i(sram_rdata_i), .err_o(err_o),
    .grant_cnt_o(grant_cnt_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model state
  int          m_ptr;
  int          fq[$];
  bit          m_err;
  int unsigned m_gcnt[N];
  int unsigned m_stall;
  logic [DW-1:0] mem[16];
  logic [DW-1:0] pend[$];

  // Stimulus for the next cycle
  logic [N-1:0]  s_req, s_we;
  logic [AW-1:0] s_addr[N];
  logic [DW-1:0] s_wdata[N], s_wmask[N];
  int            rv_mode;  // 0: RAM silent, 1: RAM answers if pending, 2: spurious pulse

  int n_vec = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0;
    fq.delete();
    m_err = 1'b0;
    m_stall = 0;
    for (int i = 0; i < N; i++) m_gcnt[i] = 0;
  endtask

  task automatic chk_stats();
    for (int i = 0; i < N; i++)
      chk($sformatf("grant_cnt%0d", i), 64'(grant_cnt_o[i*32 +: 32]), STATS ? 64'(m_gcnt[i]) : 64'd0);
    chk("stall_cnt", 64'(stall_cnt_o), STATS ? 64'(m_stall) : 64'd0);
  endtask

  task automatic cycle();
    bit rv, can, g;
    int w;
    logic [DW-1:0] rd;
    logic [N-1:0] eg, erv;
    @(negedge clk_i);
    rst_i = 1'b0;
    req_i = s_req;
    we_i  = s_we;
    for (int i = 0; i < N; i++) begin
      addr_i[i*AW +: AW]  = s_addr[i];
      wdata_i[i*DW +: DW] = s_wdata[i];
      wmask_i[i*DW +: DW] = s_wmask[i];
    end
    rv = (rv_mode == 2) || (rv_mode == 1 && pend.size() > 0);
    rd = (rv_mode == 1 && pend.size() > 0) ? pend[0] : $urandom;
    sram_rvalid_i = rv;
    sram_rdata_i  = rd;
    #1;
    can = (fq.size() < OUT) || rv;
    w = -1;
    for (int k = N - 1; k >= 0; k--) if (s_req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
    g  = can && (w >= 0);
    eg = g ? N'(1 << w) : '0;
    erv = (rv && fq.size() > 0) ? N'(1 << fq[0]) : '0;
    chk("gnt", 64'(gnt_o), 64'(eg));
    chk("sram_req", 64'(sram_req_o), 64'(g));
    if (g) begin
      chk("sram_we", 64'(sram_we_o), 64'(s_we[w]));
      chk("sram_addr", 64'(sram_addr_o), 64'(s_addr[w]));
      chk("sram_wdata", 64'(sram_wdata_o), 64'(s_wdata[w]));
      chk("sram_wmask", 64'(sram_wmask_o), 64'(s_wmask[w]));
    end
    chk("rvalid", 64'(rvalid_o), 64'(erv));
    if (erv != '0) chk("rdata", 64'(rdata_o), 64'(rd));
    chk("err", 64'(err_o), 64'(m_err));
    chk_stats();
    // advance the model to the state after the coming rising edge
    if (rv) begin
      if (fq.size() == 0) m_err = 1'b1;
      else void'(fq.pop_front());
      if (rv_mode == 1) void'(pend.pop_front());
    end
    if (s_req != '0 && !can) m_stall++;
    if (g) begin
      fq.push_back(w);
      m_ptr = (w + 1) % N;
      m_gcnt[w]++;
      if (s_we[w]) begin
        mem[s_addr[w][3:0]] = (mem[s_addr[w][3:0]] & ~s_wmask[w]) | (s_wdata[w] & s_wmask[w]);
        pend.push_back($urandom);
      end else begin
        pend.push_back(mem[s_addr[w][3:0]]);
      end
    end
  endtask

  task automatic reset_cycle();
    @(negedge clk_i);
    rst_i = 1'b1;
    req_i = '0;
    sram_rvalid_i = 1'b0;
    #1;
    chk("rst_gnt", 64'(gnt_o), 64'd0);
    chk("rst_sram_req", 64'(sram_req_o), 64'd0);
    chk("rst_rvalid", 64'(rvalid_o), 64'd0);
    model_reset();
  endtask

  task automatic set_req(input logic [N-1:0] r, input logic [N-1:0] wr, input int mode);
    s_req = r;
    s_we  = wr;
    rv_mode = mode;
    for (int i = 0; i < N; i++) begin
      s_addr[i]  = AW'($urandom_range(0, 15));
      s_wdata[i] = $urandom;
      s_wmask[i] = $urandom;
    end
  endtask

  task automatic drain();
    set_req('0, '0, 1);
    for (int i = 0; i < OUT + 2; i++) cycle();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    model_reset();
    set_req('0, '0, 0);
    reset_cycle();
    reset_cycle();
    cycle();  // idle after reset: err/counters at zero

    // 1: lone requester 0, RAM latency 1
    for (int i = 0; i < 4; i++) begin set_req(2'b01, 2'b00, 1); cycle(); end
    drain();

    // 2: both requesters held, grants alternate
    for (int i = 0; i < 4; i++) begin set_req(2'b11, 2'b00, 1); cycle(); end
    drain();

    // 3: RAM stalled, FIFO fills, then a response frees a slot with a same-cycle grant
    for (int i = 0; i < 4; i++) begin set_req(2'b11, 2'b00, 0); cycle(); end
    set_req(2'b11, 2'b00, 1); cycle();
    drain();

    // 4: masked write by requester 1, then read by requester 0
    set_req(2'b10, 2'b10, 1);
    s_addr[1] = 11'd5; s_wdata[1] = 32'hDEADBEEF; s_wmask[1] = 32'hFFFF0000;
    cycle();
    set_req(2'b01, 2'b00, 1);
    s_addr[0] = 11'd5;
    cycle();
    set_req('0, '0, 1);
    cycle();
    chk("t4_rdata", 64'(rdata_o), 64'h0000_0000_DEAD_0000);
    chk("t4_rvalid", 64'(rvalid_o), 64'd1);
    drain();

    // 5: spurious RAM response with FIFO empty
    set_req('0, '0, 2); cycle();
    set_req('0, '0, 0); cycle(); cycle();
    reset_cycle();
    set_req('0, '0, 0); cycle();

    // 6: reset with two requests outstanding; late responses are errors
    set_req(2'b11, 2'b00, 0); cycle(); cycle();
    reset_cycle();
    set_req('0, '0, 1);
    for (int i = 0; i < 4; i++) cycle();
    reset_cycle();
    set_req('0, '0, 0); cycle();

    // random traffic
    for (int t = 0; t < 400; t++) begin
      set_req(N'($urandom), N'($urandom), ($urandom_range(0, 3) != 0) ? 1 : 0);
      if (fq.size() == 0 && pend.size() == 0 && $urandom_range(0, 40) == 0) rv_mode = 2;
      cycle();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
